// File: rtl/am_lock_pkg.sv
// rtl/am_lock_pkg.sv - shared constants, field offsets and state type for AM lock
package am_lock_pkg;

  localparam int AM_LANES = 4;
  localparam int AM_ID_W  = 2;

  localparam logic [1:0] SH_CTRL = 2'b01;

  localparam int M0_LSB   = 2;
  localparam int M1_LSB   = 10;
  localparam int M2_LSB   = 18;
  localparam int BIP3_LSB = 26;
  localparam int M4_LSB   = 34;
  localparam int M5_LSB   = 42;
  localparam int M6_LSB   = 50;
  localparam int BIP7_LSB = 58;

  // Per-lane marker bytes M0, M1, M2.
  localparam logic [7:0] AM_ENC [AM_LANES][3] = '{
    '{8'h90, 8'h76, 8'h47},
    '{8'hF0, 8'hC4, 8'hE6},
    '{8'hC5, 8'h65, 8'h9B},
    '{8'hA2, 8'h79, 8'h3D}
  };

  typedef enum logic [1:0] {
    FIND     = 2'd0,
    WAIT_2ND = 2'd1,
    LOCKED   = 2'd2
  } am_state_e;

endpackage

// File: rtl/am_match_rx.sv
// rtl/am_match_rx.sv - combinational alignment-marker detector for one 66-bit block
module am_match_rx
  import am_lock_pkg::*;
#(
  parameter int BLOCK_W = 66
) (
  input  logic [BLOCK_W-1:0] data_i,
  output logic               hit_o,
  output logic [AM_ID_W-1:0] id_o
);

  logic ctrl_ok;
  logic unused_bip;

  // BIP bytes carry parity, not identity, so they never qualify a match.
  assign unused_bip = ^{data_i[BIP3_LSB +: 8], data_i[BIP7_LSB +: 8]};

  assign ctrl_ok = (data_i[1:0] == SH_CTRL) &&
                   (data_i[M4_LSB +: 8] == ~data_i[M0_LSB +: 8]) &&
                   (data_i[M5_LSB +: 8] == ~data_i[M1_LSB +: 8]) &&
                   (data_i[M6_LSB +: 8] == ~data_i[M2_LSB +: 8]);

  always_comb begin
    hit_o = 1'b0;
    id_o  = '0;
    for (int k = AM_LANES - 1; k >= 0; k--) begin
      if (ctrl_ok &&
          data_i[M0_LSB +: 8] == AM_ENC[k][0] &&
          data_i[M1_LSB +: 8] == AM_ENC[k][1] &&
          data_i[M2_LSB +: 8] == AM_ENC[k][2]) begin
        hit_o = 1'b1;
        id_o  = AM_ID_W'(k);
      end
    end
  end

endmodule

// File: rtl/am_lock_rx.sv
// rtl/am_lock_rx.sv - per-lane alignment-marker lock FSM feeding lane deskew
module am_lock_rx
  import am_lock_pkg::*;
#(
  parameter int BLOCK_W     = 66,
  parameter int LANE_N      = 4,
  parameter int AM_GAP_N    = 16384,
  parameter int INVALID_MAX = 4
) (
  input  logic                      clk,
  input  logic                      nreset,
  input  logic                      valid_i,
  input  logic                      blk_v_i,
  input  logic [BLOCK_W-1:0]        data_i,
  output logic                      blk_v_o,
  output logic [BLOCK_W-1:0]        data_o,
  output logic                      am_v_o,
  output logic                      lock_v_o,
  output logic                      lock_lost_v_o,
  output logic [$clog2(LANE_N)-1:0] lane_id_o
);

  localparam int CNT_W = $clog2(AM_GAP_N);
  localparam int ID_W  = $clog2(LANE_N);
  localparam int INV_W = $clog2(INVALID_MAX + 1);

  am_state_e          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [INV_W-1:0]   inv_q, inv_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic               blk_v_q, blk_v_d;
  logic [BLOCK_W-1:0] data_q, data_d;
  logic               am_v_q, am_v_d;
  logic               lock_v_q, lock_v_d;
  logic               lost_q, lost_d;
  logic [ID_W-1:0]    lane_id_q, lane_id_d;

  logic               hit;
  logic [AM_ID_W-1:0] hit_id;
  logic               slot;
  logic               id_match;

  am_match_rx #(.BLOCK_W(BLOCK_W)) u_match (
    .data_i (data_i),
    .hit_o  (hit),
    .id_o   (hit_id)
  );

  assign slot     = blk_v_i && (cnt_q == CNT_W'(AM_GAP_N - 1));
  assign id_match = hit && (ID_W'(hit_id) == id_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    inv_d   = inv_q;
    id_d    = id_q;
    am_v_d  = 1'b0;
    lost_d  = 1'b0;
    blk_v_d = blk_v_i;
    data_d  = blk_v_i ? data_i : data_q;

    if (blk_v_i) begin
      cnt_d = slot ? '0 : cnt_q + CNT_W'(1);
    end

    if (!valid_i) begin
      // Lane went down: drop everything and search again once it returns.
      state_d = FIND;
      cnt_d   = '0;
      inv_d   = '0;
      id_d    = '0;
      lost_d  = (state_q == LOCKED);
    end else begin
      case (state_q)
        FIND: begin
          if (blk_v_i && hit) begin
            state_d = WAIT_2ND;
            id_d    = ID_W'(hit_id);
            cnt_d   = '0;
          end
        end
        WAIT_2ND: begin
          if (slot) begin
            if (id_match) begin
              state_d = LOCKED;
              inv_d   = '0;
              am_v_d  = 1'b1;
            end else begin
              state_d = FIND;
              id_d    = '0;
            end
          end
        end
        LOCKED: begin
          if (slot) begin
            if (id_match) begin
              inv_d  = '0;
              am_v_d = 1'b1;
            end else if (inv_q == INV_W'(INVALID_MAX - 1)) begin
              state_d = FIND;
              inv_d   = '0;
              id_d    = '0;
              lost_d  = 1'b1;
            end else begin
              inv_d  = inv_q + INV_W'(1);
              am_v_d = 1'b1;
            end
          end
        end
        default: begin
          state_d = FIND;
          cnt_d   = '0;
          inv_d   = '0;
          id_d    = '0;
        end
      endcase
    end

    lock_v_d  = (state_d == LOCKED);
    lane_id_d = (state_d == LOCKED) ? id_d : '0;
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q   <= FIND;
      cnt_q     <= '0;
      inv_q     <= '0;
      id_q      <= '0;
      blk_v_q   <= 1'b0;
      data_q    <= '0;
      am_v_q    <= 1'b0;
      lock_v_q  <= 1'b0;
      lost_q    <= 1'b0;
      lane_id_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      inv_q     <= inv_d;
      id_q      <= id_d;
      blk_v_q   <= blk_v_d;
      data_q    <= data_d;
      am_v_q    <= am_v_d;
      lock_v_q  <= lock_v_d;
      lost_q    <= lost_d;
      lane_id_q <= lane_id_d;
    end
  end

  assign blk_v_o       = blk_v_q;
  assign data_o        = data_q;
  assign am_v_o        = am_v_q;
  assign lock_v_o      = lock_v_q;
  assign lock_lost_v_o = lost_q;
  assign lane_id_o     = lane_id_q;

endmodule

// File: doc/am_lock_rx.md
Name: am_lock_rx

Overview:
- Per-lane alignment-marker (AM) lock stage for the 40GBASE-R receive path.
- Sits between per-lane block lock / gearbox and the lane deskew stage, which it feeds.
- Searches each lane's 66-bit block stream for a lane marker and confirms it one AM period later.
- Then tracks marker positions and declares lock loss after 4 consecutive bad markers.
- Produces the AM strobe, lock level, lock-lost pulse, lane id and registered data for deskew.

Parameters:
- BLOCK_W, 66: block width including 2-bit sync header.
- LANE_N, 4: number of PCS lanes, i.e. the number of legal marker encodings.
- AM_GAP_N, 16384: block period between markers, marker included. Minimum 4; benches use 8.
- INVALID_MAX, 4: consecutive bad markers that cause loss of lock.

Ports:
- clk  in  1  clock
- nreset  in  1  asynchronous active-low reset
- valid_i  in  1  lane up: signal_ok & block_lock. Level.
- blk_v_i  in  1  a block is present on data_i this cycle (gearbox stall when low)
- data_i  in  BLOCK_W  received block
- blk_v_o  in/out: out  1  blk_v_i delayed 1 cycle
- data_o  out  BLOCK_W  data_i delayed 1 cycle
- am_v_o  out  1  output block is an expected marker position while locked
- lock_v_o  out  1  AM lock held
- lock_lost_v_o  out  1  one-cycle pulse on loss of lock
- lane_id_o  out  $clog2(LANE_N)  PCS lane id of the locked marker; valid while lock_v_o

Behaviour:
- Reset (nreset low, async): FSM=FIND, counter=0, invalid_cnt=0. All outputs 0; data_o is 0.
- All outputs are registered with latency 1. am_v_o, lock_v_o and lane_id_o are aligned with the same data_o block.
- Marker match (combinational, data_i valid only when blk_v_i):
  - data_i[1:0]==2'b01 (control).
  - M0=[9:2], M1=[17:10], M2=[25:18] equal to lane k's encoding.
  - [41:34], [49:42], [57:50] equal to ~M0, ~M1, ~M2.
  - BIP fields [33:26] and [65:58] are ignored.
  - Output: hit, plus id k (lowest k wins; encodings are disjoint).
- Block counter: advances only on blk_v_i. Wraps from AM_GAP_N-1 to 0. The expected marker slot is counter==AM_GAP_N-1 with blk_v_i.
- FIND:
  - On blk_v_i & hit: capture id, counter=0, go WAIT_2ND.
- WAIT_2ND:
  - At the slot, hit with the same id: go LOCKED, invalid_cnt=0. The same block is output with am_v_o=1 and lock_v_o=1.
  - At the slot, anything else: go FIND. That block is not re-evaluated.
- LOCKED:
  - At each slot: am_v_o=1 regardless of match.
  - Hit with the locked id: invalid_cnt=0.
  - Otherwise (including a hit with a different id): invalid_cnt+1.
  - The INVALID_MAX-th consecutive bad marker: go FIND, lock_v_o drops on that output cycle, lock_lost_v_o pulses the same cycle, and am_v_o=0 for that block.
- valid_i low:
  - In any state, go FIND next edge and clear counter and invalid_cnt.
  - If LOCKED, pulse lock_lost_v_o once.
  - The block on that cycle is not searched.
  - Staying low holds FIND with no further pulses.
- blk_v_i low: no state change. am_v_o=0 on that output cycle, and data_o holds its previous value.
- lane_id_o holds its value while LOCKED and clears to 0 on entering FIND.

Decomposition:
- Package am_lock_pkg:
  - AM_ENC[LANE_N][3][8] constants: lane0 90/76/47, lane1 F0/C4/E6, lane2 C5/65/9B, lane3 A2/79/3D.
  - Sync-header control constant 2'b01.
  - Field bit-offset localparams.
  - FSM state enum {FIND, WAIT_2ND, LOCKED}.
- Sub-module am_match_rx: combinational; ports data_i in, hit_o out, id_o out. Instantiated once per block.

Test Plan (AM_GAP_N=8):
- Acquisition: reset, valid_i=1, blk_v_i=1, lane2 marker at block 0 and block 8 -> lock_v_o=1 and am_v_o=1 on the output cycle of block 8, lane_id_o=2. am_v_o=1 again for block 16.
- Wrong second marker: lane1 marker at 0, lane3 marker at 8 -> lock_v_o stays 0. A lane1 marker at 16 becomes the new first marker, so lock on the marker at 24.
- Lock loss: locked on lane0; corrupt markers at 4 consecutive slots -> lock_lost_v_o pulses exactly once on the 4th. lock_v_o=0 from that cycle.
- Recovery count reset: 3 bad, 1 good, 3 bad -> lock held, no pulse.
- Gearbox stall: locked, blk_v_i low for 2 cycles mid-period -> counter frozen, am_v_o still lands on the marker block, and lock is held.
- Drop and reset: valid_i low while locked -> one lock_lost_v_o pulse and state FIND. Async nreset mid-WAIT_2ND -> all outputs 0 immediately, and reacquisition needs two fresh markers.
